// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock/relock controller.
// Contents: FSM state encodings, PLL code widths and defaults,
// lock-qualification counts, counter widths and a saturating-increment helper.
package pll_ctrl_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CODE_W  = 4;
    localparam int unsigned TIMER_W = 20;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned QUAL_W  = 3;

    // FSM state encodings
    localparam logic [STATE_W-1:0] RST_ASSERT = 2'd0;
    localparam logic [STATE_W-1:0] WAIT_LOCK  = 2'd1;
    localparam logic [STATE_W-1:0] LOCKED     = 2'd2;
    localparam logic [STATE_W-1:0] FAULT      = 2'd3;

    // PLL code values after reset
    localparam logic [CODE_W-1:0] PSDA_DEFAULT   = 4'b0000;
    localparam logic [CODE_W-1:0] DUTYDA_DEFAULT = 4'b1000;

    // Consecutive synchronized-lock cycles needed to declare lock / loss of lock
    localparam int unsigned LOCK_QUAL_CNT = 4;
    localparam int unsigned LOSS_QUAL_CNT = 2;

    // Phase/duty setting payload
    typedef struct packed {
        logic [CODE_W-1:0] psda;
        logic [CODE_W-1:0] dutyda;
    } cfg_t;

    // Increment that holds at lim instead of wrapping
    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v,
                                                   input logic [RETRY_W-1:0] lim);
        return (v >= lim) ? v : v + RETRY_W'(1);
    endfunction

endpackage

// File: rtl/pll_ctrl_if.sv
// Phase/duty configuration handshake between a requester and pll_ctrl.
// Signals: cfg_valid (setting offered), cfg_psda / cfg_dutyda (requested codes),
//          cfg_ready (controller accepts on cfg_valid && cfg_ready).
// Modports: master = requester, slave = pll_ctrl.
interface pll_ctrl_if;
    import pll_ctrl_pkg::*;

    logic              cfg_valid;
    logic [CODE_W-1:0] cfg_psda;
    logic [CODE_W-1:0] cfg_dutyda;
    logic              cfg_ready;

    modport master (output cfg_valid, output cfg_psda, output cfg_dutyda, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_psda, input  cfg_dutyda, output cfg_ready);
endinterface

// File: rtl/pll_ctrl_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Ports: clk, rst (async active-high, clears both flops), d (async input),
//        q (synchronized output, two clk cycles of latency).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_ctrl.sv
// PLL reset/lock supervisor: pulses PLL RESET, qualifies LOCK, retries on
// timeout or lock loss up to a retry budget, and applies phase/duty settings
// while locked.
// Ports: clk, rst (async active-high), pll_lock (raw async LOCK), fault_clr,
//        cfg (slave handshake for PSDA/DUTYDA settings), pll_reset, pll_psda,
//        pll_dutyda, locked, fault, retry_cnt.
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 12000,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    input  logic               fault_clr,
    pll_ctrl_if.slave          cfg,
    output logic               pll_reset,
    output logic [CODE_W-1:0]  pll_psda,
    output logic [CODE_W-1:0]  pll_dutyda,
    output logic               locked,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [QUAL_W-1:0]  LOCK_LAST = QUAL_W'(LOCK_QUAL_CNT - 1);
    localparam logic [QUAL_W-1:0]  LOSS_LAST = QUAL_W'(LOSS_QUAL_CNT - 1);

    logic [STATE_W-1:0] state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [QUAL_W-1:0]  qual, qual_nxt;
    logic [RETRY_W-1:0] retry_nxt, retry_bump;
    logic               lock_s;
    logic               ready_q;
    logic               cfg_hs;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // State, timer, qualification counter and retry count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_ASSERT;
            timer     <= '0;
            qual      <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            qual      <= qual_nxt;
            retry_cnt <= retry_nxt;
        end
    end

    // Next-state logic; qual counts lock-high cycles in WAIT_LOCK and
    // lock-low cycles in LOCKED, and is cleared on every state change.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        qual_nxt   = qual;
        retry_nxt  = retry_cnt;
        retry_bump = sat_inc(retry_cnt, RETRY_MAX);

        case (state)
            RST_ASSERT: begin
                qual_nxt = '0;
                if (timer == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end

            WAIT_LOCK: begin
                qual_nxt = lock_s ? ((qual == LOCK_LAST) ? qual : qual + QUAL_W'(1)) : '0;
                if (lock_s && (qual == LOCK_LAST)) begin
                    state_nxt = LOCKED;
                    timer_nxt = '0;
                    qual_nxt  = '0;
                    retry_nxt = '0;
                end else if (timer == TO_LAST) begin
                    state_nxt = (retry_bump >= RETRY_MAX) ? FAULT : RST_ASSERT;
                    timer_nxt = '0;
                    qual_nxt  = '0;
                    retry_nxt = retry_bump;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end

            LOCKED: begin
                timer_nxt = '0;
                if (lock_s) begin
                    qual_nxt = '0;
                end else if (qual == LOSS_LAST) begin
                    state_nxt = (retry_bump >= RETRY_MAX) ? FAULT : RST_ASSERT;
                    qual_nxt  = '0;
                    retry_nxt = retry_bump;
                end else begin
                    qual_nxt = qual + QUAL_W'(1);
                end
            end

            FAULT: begin
                timer_nxt = '0;
                qual_nxt  = '0;
                if (fault_clr) begin
                    state_nxt = RST_ASSERT;
                    retry_nxt = '0;
                end
            end

            default: begin
                state_nxt = RST_ASSERT;
                timer_nxt = '0;
                qual_nxt  = '0;
            end
        endcase
    end

    // Status outputs registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_reset <= 1'b1;
            locked    <= 1'b0;
            fault     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            pll_reset <= (state_nxt == RST_ASSERT) || (state_nxt == FAULT);
            locked    <= (state_nxt == LOCKED);
            fault     <= (state_nxt == FAULT);
            ready_q   <= (state_nxt == LOCKED);
        end
    end

    assign cfg.cfg_ready = ready_q;

    // ready_q is high for every LOCKED cycle, including the lock-loss cycle
    assign cfg_hs = cfg.cfg_valid && ready_q;

    // Phase/duty codes persist across relock attempts; only rst restores defaults
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_psda   <= PSDA_DEFAULT;
            pll_dutyda <= DUTYDA_DEFAULT;
        end else if (cfg_hs) begin
            pll_psda   <= cfg.cfg_psda;
            pll_dutyda <= cfg.cfg_dutyda;
        end
    end

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed self-checking bench for pll_ctrl (RESET_CYCLES=16, LOCK_TIMEOUT=64,
// MAX_RETRIES=3). Inputs change and outputs are sampled 1 ns after posedge.
module tb_pll_ctrl;
    import pll_ctrl_pkg::*;

    localparam int unsigned RC = 16;
    localparam int unsigned LT = 64;
    localparam int unsigned MR = 3;

    logic               clk       = 1'b0;
    logic               rst       = 1'b1;
    logic               pll_lock  = 1'b0;
    logic               fault_clr = 1'b0;
    logic               pll_reset;
    logic [CODE_W-1:0]  pll_psda;
    logic [CODE_W-1:0]  pll_dutyda;
    logic               locked;
    logic               fault;
    logic [RETRY_W-1:0] retry_cnt;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    pll_ctrl_if cfg_bus ();

    pll_ctrl #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .MAX_RETRIES  (MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .fault_clr  (fault_clr),
        .cfg        (cfg_bus.slave),
        .pll_reset  (pll_reset),
        .pll_psda   (pll_psda),
        .pll_dutyda (pll_dutyda),
        .locked     (locked),
        .fault      (fault),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycles until pll_reset is seen low, bounded
    task automatic measure_reset(output int n);
        n = 0;
        while (n < 300) begin
            step(1);
            n++;
            if (!pll_reset) break;
        end
    endtask

    // Cycles until retry_cnt changes, bounded
    task automatic measure_retry(output int n);
        logic [RETRY_W-1:0] prev;
        prev = retry_cnt;
        n = 0;
        while (n < 200 && retry_cnt == prev) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int n;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_psda   = 4'h0;
        cfg_bus.cfg_dutyda = 4'h0;

        // Reset values
        step(3);
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_locked",    32'(locked),    32'd0);
        chk("rst_fault",     32'(fault),     32'd0);
        chk("rst_retry",     32'(retry_cnt), 32'd0);
        chk("rst_ready",     32'(cfg_bus.cfg_ready), 32'd0);
        chk("rst_psda",      32'(pll_psda),   32'h0);
        chk("rst_dutyda",    32'(pll_dutyda), 32'h8);

        // Reset pulse length after release
        rst = 1'b0;
        measure_reset(n);
        chk("reset_len_initial", 32'(n), 32'd16);

        // Setting offered in WAIT_LOCK is not accepted
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_psda   = 4'h3;
        cfg_bus.cfg_dutyda = 4'h2;
        chk("wait_ready_low", 32'(cfg_bus.cfg_ready), 32'd0);
        step(1);
        cfg_bus.cfg_valid = 1'b0;
        chk("wait_psda_hold",   32'(pll_psda),   32'h0);
        chk("wait_dutyda_hold", 32'(pll_dutyda), 32'h8);

        // Lock arrives 40 cycles after pll_reset fell: 2 sync + 4 qualify cycles
        step(38);
        pll_lock = 1'b1;
        n = 0;
        while (n < 20 && !locked) begin
            step(1);
            n++;
        end
        chk("lock_latency", 32'(n), 32'd6);
        chk("lock_retry",   32'(retry_cnt), 32'd0);
        chk("lock_pll_reset", 32'(pll_reset), 32'd0);
        chk("lock_fault",   32'(fault), 32'd0);

        // Handshake while locked
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_psda   = 4'h5;
        cfg_bus.cfg_dutyda = 4'h6;
        chk("locked_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        step(1);
        cfg_bus.cfg_valid = 1'b0;
        chk("cfg_psda",      32'(pll_psda),   32'h5);
        chk("cfg_dutyda",    32'(pll_dutyda), 32'h6);
        chk("cfg_no_reset",  32'(pll_reset),  32'd0);
        chk("cfg_locked",    32'(locked),     32'd1);

        // One-cycle glitch is filtered
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(6);
        chk("glitch_locked", 32'(locked),    32'd1);
        chk("glitch_retry",  32'(retry_cnt), 32'd0);

        // Sustained drop; handshake lands on the detection cycle
        pll_lock = 1'b0;
        step(3);
        chk("drop_still_locked", 32'(locked), 32'd1);
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_psda   = 4'h9;
        cfg_bus.cfg_dutyda = 4'hA;
        step(1);
        cfg_bus.cfg_valid = 1'b0;
        chk("drop_locked",    32'(locked),     32'd0);
        chk("drop_retry",     32'(retry_cnt),  32'd1);
        chk("drop_pll_reset", 32'(pll_reset),  32'd1);
        chk("drop_ready",     32'(cfg_bus.cfg_ready), 32'd0);
        chk("drop_psda",      32'(pll_psda),   32'h9);
        chk("drop_dutyda",    32'(pll_dutyda), 32'hA);

        // Relock attempt: fresh reset pulse, codes retained
        measure_reset(n);
        chk("reset_len_relock", 32'(n), 32'd16);
        chk("relock_psda_kept", 32'(pll_psda), 32'h9);
        chk("relock_retry",     32'(retry_cnt), 32'd1);

        // Async reset mid WAIT_LOCK
        step(5);
        rst = 1'b1;
        #1;
        chk("arst_pll_reset", 32'(pll_reset),  32'd1);
        chk("arst_locked",    32'(locked),     32'd0);
        chk("arst_fault",     32'(fault),      32'd0);
        chk("arst_retry",     32'(retry_cnt),  32'd0);
        chk("arst_ready",     32'(cfg_bus.cfg_ready), 32'd0);
        chk("arst_psda",      32'(pll_psda),   32'h0);
        chk("arst_dutyda",    32'(pll_dutyda), 32'h8);
        step(2);
        rst = 1'b0;
        measure_reset(n);
        chk("reset_len_after_arst", 32'(n), 32'd16);

        // Lock never comes: three timeouts lead to FAULT
        for (int k = 1; k <= 3; k++) begin
            measure_retry(n);
            chk("timeout_len",   32'(n),         32'd64);
            chk("timeout_retry", 32'(retry_cnt), 32'(k));
            chk("timeout_pll_reset", 32'(pll_reset), 32'd1);
            if (k < 3) begin
                chk("timeout_no_fault", 32'(fault), 32'd0);
                if (k == 1) begin
                    // fault_clr outside FAULT has no effect; uses one reset cycle
                    fault_clr = 1'b1;
                    step(1);
                    fault_clr = 1'b0;
                    chk("clr_ignored_retry", 32'(retry_cnt), 32'd1);
                    measure_reset(n);
                    chk("reset_len_retry1", 32'(n), 32'd15);
                end else begin
                    measure_reset(n);
                    chk("reset_len_retry2", 32'(n), 32'd16);
                end
            end
        end
        chk("fault_set",    32'(fault),  32'd1);
        chk("fault_locked", 32'(locked), 32'd0);
        step(5);
        chk("fault_held",   32'(fault), 32'd1);
        chk("fault_retry_sat", 32'(retry_cnt), 32'd3);
        chk("fault_ready",  32'(cfg_bus.cfg_ready), 32'd0);

        // Leave FAULT
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        chk("clr_fault",     32'(fault),     32'd0);
        chk("clr_retry",     32'(retry_cnt), 32'd0);
        chk("clr_pll_reset", 32'(pll_reset), 32'd1);
        measure_reset(n);
        chk("reset_len_after_clr", 32'(n), 32'd16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
